// File: rtl/alu_decode_pkg.sv
// Shared decode definitions: opcode groups, ALU operation codes and the decoded-entry record.
package alu_decode_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'h00;
    localparam logic [4:0] OPC_OP_IMM = 5'h04;
    localparam logic [4:0] OPC_AUIPC  = 5'h05;
    localparam logic [4:0] OPC_STORE  = 5'h08;
    localparam logic [4:0] OPC_OP     = 5'h0C;
    localparam logic [4:0] OPC_LUI    = 5'h0D;
    localparam logic [4:0] OPC_BRANCH = 5'h18;
    localparam logic [4:0] OPC_JALR   = 5'h19;
    localparam logic [4:0] OPC_JAL    = 5'h1B;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    localparam int ALU_CODE_W = 5;
    typedef logic [ALU_CODE_W-1:0] alu_code_t;

    localparam alu_code_t ALU_ADD    = 5'h00;
    localparam alu_code_t ALU_SUB    = 5'h01;
    localparam alu_code_t ALU_SLL    = 5'h04;
    localparam alu_code_t ALU_SRL    = 5'h06;
    localparam alu_code_t ALU_SRA    = 5'h07;
    localparam alu_code_t ALU_AND    = 5'h09;
    localparam alu_code_t ALU_OR     = 5'h0A;
    localparam alu_code_t ALU_XOR    = 5'h0B;
    localparam alu_code_t ALU_SLTU   = 5'h0C;
    localparam alu_code_t ALU_SLT    = 5'h0D;
    localparam alu_code_t ALU_MUL    = 5'h10;
    localparam alu_code_t ALU_MULH   = 5'h11;
    localparam alu_code_t ALU_MULHSU = 5'h12;
    localparam alu_code_t ALU_MULHU  = 5'h13;
    localparam alu_code_t ALU_DIV    = 5'h14;
    localparam alu_code_t ALU_DIVU   = 5'h15;
    localparam alu_code_t ALU_REM    = 5'h16;
    localparam alu_code_t ALU_REMU   = 5'h17;

    typedef struct packed {
        logic [31:0] instr;
        alu_code_t   alu_op;
        logic        is_branch;
        logic [2:0]  br_cond;
        logic        illegal;
    } dec_entry_t;

    // funct3 map shared by OP-IMM and OP; arith only distinguishes SRA from SRL.
    function automatic alu_code_t base_op(input logic [2:0] f3, input logic arith);
        alu_code_t op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = arith ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I/RV32M instruction -> decoded entry; no state, no handshake.
module alu_op_decoder
    import alu_decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] i_instr,
    output dec_entry_t  o_entry
);

    logic [4:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    alu_code_t  w_op;
    logic       w_ill;
    logic       w_br;
    logic [2:0] w_cond;

    assign w_opc = i_instr[6:2];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    always_comb begin
        w_ill  = 1'b1;
        w_op   = ALU_ADD;
        w_br   = 1'b0;
        w_cond = 3'b000;
        if (i_instr[1:0] == 2'b11) begin
            case (w_opc)
                OPC_OP_IMM: begin
                    // funct7 is immediate data except for the shift encodings
                    w_op = base_op(w_f3, w_f7 == F7_ALT);
                    if (w_f3 == 3'b001)
                        w_ill = (w_f7 != F7_BASE);
                    else if (w_f3 == 3'b101)
                        w_ill = !((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
                    else
                        w_ill = 1'b0;
                end
                OPC_OP: begin
                    if (w_f7 == F7_BASE) begin
                        w_op  = base_op(w_f3, 1'b0);
                        w_ill = 1'b0;
                    end else if (w_f7 == F7_ALT) begin
                        if (w_f3 == 3'b000) begin
                            w_op  = ALU_SUB;
                            w_ill = 1'b0;
                        end else if (w_f3 == 3'b101) begin
                            w_op  = ALU_SRA;
                            w_ill = 1'b0;
                        end
                    end else if ((w_f7 == F7_MUL) && ENABLE_M) begin
                        w_op  = {2'b10, w_f3};
                        w_ill = 1'b0;
                    end
                end
                OPC_BRANCH: begin
                    w_br   = 1'b1;
                    w_cond = w_f3;
                    case (w_f3[2:1])
                        2'b00:   begin w_op = ALU_SUB;  w_ill = 1'b0; end
                        2'b10:   begin w_op = ALU_SLT;  w_ill = 1'b0; end
                        2'b11:   begin w_op = ALU_SLTU; w_ill = 1'b0; end
                        default: w_ill = 1'b1;
                    endcase
                end
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: begin
                    w_ill = 1'b0;
                end
                default: w_ill = 1'b1;
            endcase
        end
        if (w_ill) begin
            w_op   = ALU_ADD;
            w_br   = 1'b0;
            w_cond = 3'b000;
        end
    end

    assign o_entry.instr     = i_instr;
    assign o_entry.alu_op    = w_op;
    assign o_entry.is_branch = w_br;
    assign o_entry.br_cond   = w_cond;
    assign o_entry.illegal   = w_ill;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: 1-cycle accept-to-valid, full 1/cycle throughput.
// Two-entry head+skid buffer so in_ready comes from a flop; flush drops everything.
module alu_decode_stage
    import alu_decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter int ALU_OP_W = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_is_branch,
    output logic [2:0]          out_br_cond,
    output logic                out_illegal,
    output logic [CNT_W-1:0]    illegal_cnt
);

    dec_entry_t       w_dec;
    dec_entry_t       r_head;
    dec_entry_t       r_skid;
    dec_entry_t       w_head_nxt;
    dec_entry_t       w_skid_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic             r_in_rdy;
    logic             w_acc;
    logic             w_pop;
    logic [CNT_W-1:0] r_ill_cnt;

    alu_op_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .i_instr (in_instr),
        .o_entry (w_dec)
    );

    assign w_acc = in_valid && r_in_rdy && !flush;
    assign w_pop = (r_cnt != 2'd0) && out_ready;

    always_comb begin
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        w_cnt_nxt  = r_cnt;
        if (flush) begin
            w_cnt_nxt = 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_acc) begin
                        w_head_nxt = w_dec;
                        w_cnt_nxt  = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_acc && w_pop) begin
                        w_head_nxt = w_dec;
                    end else if (w_acc) begin
                        w_skid_nxt = w_dec;
                        w_cnt_nxt  = 2'd2;
                    end else if (w_pop) begin
                        w_cnt_nxt = 2'd0;
                    end
                end
                default: begin
                    // full: in_ready is low, so only a pop can move the buffer
                    if (w_pop) begin
                        w_head_nxt = r_skid;
                        w_cnt_nxt  = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_skid    <= '0;
            r_cnt     <= 2'd0;
            r_in_rdy  <= 1'b1;
            r_ill_cnt <= '0;
        end else begin
            r_head   <= w_head_nxt;
            r_skid   <= w_skid_nxt;
            r_cnt    <= w_cnt_nxt;
            r_in_rdy <= (w_cnt_nxt <= 2'd1);
            if (w_acc && w_dec.illegal && (r_ill_cnt != '1))
                r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign in_ready      = r_in_rdy;
    assign out_valid     = (r_cnt != 2'd0);
    assign out_instr     = r_head.instr;
    assign out_alu_op    = ALU_OP_W'(r_head.alu_op);
    assign out_is_branch = r_head.is_branch;
    assign out_br_cond   = r_head.br_cond;
    assign out_illegal   = r_head.illegal;
    assign illegal_cnt   = r_ill_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench: M-enabled stage and an M-disabled, 4-bit-counter stage share the same stimulus.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    logic        a_in_ready, a_out_valid, a_is_br, a_ill;
    logic [31:0] a_instr;
    logic [4:0]  a_op;
    logic [2:0]  a_cond;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_is_br, b_ill;
    logic [31:0] b_instr;
    logic [3:0]  b_op;
    logic [2:0]  b_cond;
    logic [3:0]  b_cnt;

    int n_applied = 0;
    int n_err     = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.ENABLE_M(1'b1), .ALU_OP_W(5), .CNT_W(16)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_instr),
        .out_alu_op(a_op), .out_is_branch(a_is_br), .out_br_cond(a_cond),
        .out_illegal(a_ill), .illegal_cnt(a_cnt)
    );

    alu_decode_stage #(.ENABLE_M(1'b0), .ALU_OP_W(4), .CNT_W(4)) u_dut_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_instr),
        .out_alu_op(b_op), .out_is_branch(b_is_br), .out_br_cond(b_cond),
        .out_illegal(b_ill), .illegal_cnt(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  op;
        logic        br;
        logic [2:0]  cond;
        logic        ill;
        logic        is_m;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{32'h40208033, 5'h01, 1'b0, 3'd0, 1'b0, 1'b0}; // sub
        vecs[1]  = '{32'h00208033, 5'h00, 1'b0, 3'd0, 1'b0, 1'b0}; // add
        vecs[2]  = '{32'h02208033, 5'h10, 1'b0, 3'd0, 1'b0, 1'b1}; // mul
        vecs[3]  = '{32'h00208463, 5'h01, 1'b1, 3'd0, 1'b0, 1'b0}; // beq
        vecs[4]  = '{32'h0020A463, 5'h00, 1'b0, 3'd0, 1'b1, 1'b0}; // branch f3=010
        vecs[5]  = '{32'h0020F463, 5'h0C, 1'b1, 3'd7, 1'b0, 1'b0}; // bgeu
        vecs[6]  = '{32'h0020C463, 5'h0D, 1'b1, 3'd4, 1'b0, 1'b0}; // blt
        vecs[7]  = '{32'h00500093, 5'h00, 1'b0, 3'd0, 1'b0, 1'b0}; // addi
        vecs[8]  = '{32'h4030D093, 5'h07, 1'b0, 3'd0, 1'b0, 1'b0}; // srai
        vecs[9]  = '{32'h40309093, 5'h00, 1'b0, 3'd0, 1'b1, 1'b0}; // slli, bad funct7
        vecs[10] = '{32'h000010B7, 5'h00, 1'b0, 3'd0, 1'b0, 1'b0}; // lui
        vecs[11] = '{32'h00000000, 5'h00, 1'b0, 3'd0, 1'b1, 1'b0}; // low bits 00
        vecs[12] = '{32'h40209033, 5'h00, 1'b0, 3'd0, 1'b1, 1'b0}; // op f7=20 f3=001
        vecs[13] = '{32'h0020C033, 5'h0B, 1'b0, 3'd0, 1'b0, 1'b0}; // xor
        vecs[14] = '{32'h0030B093, 5'h0C, 1'b0, 3'd0, 1'b0, 1'b0}; // sltiu
        vecs[15] = '{32'h0000000B, 5'h00, 1'b0, 3'd0, 1'b1, 1'b0}; // custom opcode
        vecs[16] = '{32'h0220D033, 5'h15, 1'b0, 3'd0, 1'b0, 1'b1}; // divu
        vecs[17] = '{32'h80208033, 5'h00, 1'b0, 3'd0, 1'b1, 1'b0}; // op f7=40
        vecs[18] = '{32'h0000006F, 5'h00, 1'b0, 3'd0, 1'b0, 1'b0}; // jal

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
        repeat (2) tick();
        chk("rst a out_valid", a_out_valid, 0);
        chk("rst a in_ready", a_in_ready, 1);
        chk("rst a cnt", a_cnt, 0);
        chk("rst a alu_op", a_op, 0);
        chk("rst a instr", a_instr, 0);
        chk("rst a illegal", a_ill, 0);
        chk("rst b cnt", b_cnt, 0);
        rst_n = 1'b1;
        tick();

        // table: one instruction per cycle, out_ready high
        for (int i = 0; i < NV; i++) begin
            logic [4:0] eb_op;
            logic       eb_ill, eb_br;
            logic [2:0] eb_cond;
            eb_ill  = vecs[i].ill | vecs[i].is_m;
            eb_op   = vecs[i].is_m ? 5'h00 : vecs[i].op;
            eb_br   = vecs[i].is_m ? 1'b0 : vecs[i].br;
            eb_cond = vecs[i].is_m ? 3'd0 : vecs[i].cond;
            in_instr = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d a valid", i), a_out_valid, 1);
            chk($sformatf("v%0d a instr", i), a_instr, vecs[i].instr);
            chk($sformatf("v%0d a op", i), a_op, vecs[i].op);
            chk($sformatf("v%0d a br", i), a_is_br, vecs[i].br);
            chk($sformatf("v%0d a cond", i), a_cond, vecs[i].cond);
            chk($sformatf("v%0d a ill", i), a_ill, vecs[i].ill);
            chk($sformatf("v%0d b op", i), b_op, eb_op[3:0]);
            chk($sformatf("v%0d b ill", i), b_ill, eb_ill);
            chk($sformatf("v%0d b br", i), b_is_br, eb_br);
            chk($sformatf("v%0d b cond", i), b_cond, eb_cond);
            if (vecs[i].ill) exp_cnt_a++;
            if (eb_ill && exp_cnt_b < 15) exp_cnt_b++;
            chk($sformatf("v%0d a cnt", i), a_cnt, exp_cnt_a);
            chk($sformatf("v%0d b cnt", i), b_cnt, exp_cnt_b);
        end
        tick();
        chk("drain a valid", a_out_valid, 0);

        // backpressure: three offered, two accepted, then drained in order
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00208033;
        tick();
        chk("bp in_ready after 1", a_in_ready, 1);
        chk("bp head A", a_instr, 32'h00208033);
        in_instr = 32'h40208033;
        tick();
        chk("bp in_ready after 2", a_in_ready, 0);
        chk("bp b in_ready after 2", b_in_ready, 0);
        in_instr = 32'h0020C033;
        tick();
        chk("bp stall in_ready", a_in_ready, 0);
        chk("bp stall head", a_instr, 32'h00208033);
        chk("bp stall op", a_op, 5'h00);
        out_ready = 1'b1;
        tick();
        chk("bp pop1 head B", a_instr, 32'h40208033);
        chk("bp pop1 op", a_op, 5'h01);
        chk("bp pop1 in_ready", a_in_ready, 1);
        tick();
        chk("bp pop2 head C", a_instr, 32'h0020C033);
        chk("bp pop2 valid", a_out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("bp empty", a_out_valid, 0);

        // flush with two entries and an illegal word on the input
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00208033;
        tick();
        in_instr = 32'h40208033;
        tick();
        chk("fl full", a_in_ready, 0);
        flush = 1'b1; in_instr = 32'h00000000;
        tick();
        chk("fl valid", a_out_valid, 0);
        chk("fl in_ready", a_in_ready, 1);
        chk("fl cnt", a_cnt, exp_cnt_a);
        // flush on empty while in_ready is high: word is dropped, not counted
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2 valid", a_out_valid, 0);
        chk("fl2 cnt a", a_cnt, exp_cnt_a);
        chk("fl2 cnt b", b_cnt, exp_cnt_b);

        // reset mid-stream drops the buffered entry and clears the counter
        in_valid = 1'b1; in_instr = 32'h00000000;
        tick();
        chk("mr pre valid", a_out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr valid", a_out_valid, 0);
        chk("mr in_ready", a_in_ready, 1);
        chk("mr cnt a", a_cnt, 0);
        chk("mr cnt b", b_cnt, 0);

        // counter saturation on the 4-bit instance, back-to-back illegal words
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("sat b cnt k%0d", k), b_cnt, (k > 15) ? 15 : k);
            chk($sformatf("sat in_ready k%0d", k), b_in_ready, 1);
        end
        chk("sat a cnt", a_cnt, 16);
        in_valid = 1'b0;
        tick();
        chk("sat b hold", b_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

- Registered decode stage that turns a 32-bit RV32I/RV32M instruction word into an ALU operation code, branch condition and illegal-instruction flag.
- Sits between the fetch register and execute, with valid/ready handshakes on both sides.
- A two-entry skid buffer lets `in_ready` be driven from a flop.
- Also provides an optional M-extension decode, a flush, and a saturating illegal-instruction counter.

## Interface
- `ENABLE_M`, 1: when 1, OP with funct7=0x01 decodes to M ops; when 0 it is illegal.
- `ALU_OP_W`, 5: width of `out_alu_op`; must be ≥5 when `ENABLE_M`=1 and ≥4 otherwise. Codes are zero-extended.
- `CNT_W`, 16: width of the illegal counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all buffered entries.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  decoded entry available.
- `out_ready`  in  1  execute accepts.
- `out_instr`  out  32  instruction passed through.
- `out_alu_op`  out  ALU_OP_W  ALU operation.
- `out_is_branch`  out  1  opcode is BRANCH.
- `out_br_cond`  out  3  funct3 of a branch; 0 otherwise.
- `out_illegal`  out  1  instruction not decodable.
- `illegal_cnt`  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- **ALU codes:**
  - ADD 0x00, SUB 0x01, SLL 0x04, SRL 0x06, SRA 0x07, AND 0x09, OR 0x0A, XOR 0x0B, SLTU 0x0C, SLT 0x0D.
  - M ops: MUL 0x10, MULH 0x11, MULHSU 0x12, MULHU 0x13, DIV 0x14, DIVU 0x15, REM 0x16, REMU 0x17.
- **OP-IMM (opcode[6:2]=0x04):**
  - funct3 maps 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA, 110 OR, 111 AND.
  - 101 selects SRA when funct7=0x20 and SRL when funct7=0x00.
  - For 001/101, any other funct7 is illegal.
- **OP (0x0C):**
  - funct7=0x00: the same funct3 map.
  - funct7=0x20: only funct3 000 (SUB) and 101 (SRA) are legal.
  - funct7=0x01: M op 0x10+funct3 when `ENABLE_M`, illegal otherwise.
  - Any other funct7 is illegal.
- **BRANCH (0x18):**
  - `out_is_branch`=1 and `out_br_cond`=funct3.
  - funct3 000/001 decode to SUB; 100/101 to SLT; 110/111 to SLTU.
  - funct3 010/011 are illegal.
- **LUI, AUIPC, JAL, JALR, LOAD, STORE** (0x0D, 0x05, 0x1B, 0x19, 0x00, 0x08): ADD, legal.
- **Other opcodes, or instr[1:0]≠2'b11:** ADD, illegal.
- **Illegal entries:** always `out_alu_op`=ADD, `out_is_branch`=0, `out_br_cond`=0.
- **Buffer:**
  - Decode is combinational on `in_instr`; the result is written into a two-entry FIFO (main + skid).
  - Accept when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
  - `in_ready` = (entries registered next cycle ≤ 1), computed from next-state count so it is a flop output.
- **Counter:** `illegal_cnt` increments on each accepted illegal entry and saturates at all-ones; `flush` does not clear it.

## Timing
- **Reset:**
  - FIFO empty, `out_valid`=0, `in_ready`=1, `illegal_cnt`=0.
  - All payload outputs are 0 (`out_alu_op`=ADD).
- **Latency:** 1 cycle from accept to `out_valid`. Zero-bubble throughput of 1/cycle when `out_ready` is held high.
- **Simultaneous events:**
  - Accept and pop in the same cycle with 1 entry: count stays 1 and the new entry becomes head next cycle.
  - With 2 entries, `in_ready`=0, so no accept can occur.
- **Flush:**
  - Wins over accept and pop; count→0 next cycle and `in_ready`=1 next cycle.
  - An instruction presented with `flush` is dropped and not counted.
- **Output stability:** payload holds while `out_valid && !out_ready`.
- **Reset mid-stream:** in-flight entries are lost, and `illegal_cnt` clears.

## Structure
- Shared package `alu_decode_pkg`:
  - opcode constants;
  - the ALU code constants above;
  - the decoded-entry struct (instr, alu_op, is_branch, br_cond, illegal).
- Sub-module `alu_op_decoder`: purely combinational instruction→entry, parametrised by `ENABLE_M`.
- The top level holds the two-entry buffer, the handshake and the counter.

## Test plan
- Reset, then `in_valid` with 0x40208033 (SUB) and `out_ready`=1 → next cycle `out_valid`=1, `out_alu_op`=0x01, illegal=0.
- 0x02208033 (MUL) with `ENABLE_M`=1 → 0x10; with `ENABLE_M`=0 → ADD, `out_illegal`=1, `illegal_cnt` 0→1.
- BEQ 0x00208463 → is_branch=1, br_cond=0, op SUB. Branch word with funct3=010 → illegal.
- Hold `out_ready`=0 and send 3 instructions → 2 accepted, `in_ready`=0 after the second. Release → outputs in order, 1 per cycle.
- `flush` with 2 entries and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, counter unchanged.
- Force `illegal_cnt` to all-ones with `CNT_W`=4 by 16 illegal words → stays 15.
